// File: rtl/cmp_pkg.sv
// Shared types and default sizing for the shared-comparator sequencer.
package cmp_pkg;

    localparam int unsigned N_REQ_DEF = 4;
    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned NIB       = WIDTH_DEF / 4;
    localparam int unsigned IDW       = $clog2(N_REQ_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_4bit.sv
// Existing combinational 4-bit magnitude comparator macro.
// Its gt output asserts when b exceeds a; lt asserts when a exceeds b.
module cmp_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    assign gt = (b > a);
    assign eq = (a == b);
    assign lt = (a > b);

endmodule

// File: rtl/cmp_rr_arb.sv
// Combinational round-robin pick: first valid requester after last_grant,
// searching upward and wrapping modulo N_REQ.
module cmp_rr_arb #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_grant,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx
);

    localparam int unsigned IW = $clog2(N_REQ);

    logic found;

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop can infer a latch.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            int unsigned idx;
            idx = (int'(last_grant) + off) % N_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/cmp_share_sequencer.sv
// Round-robin sharing of one cmp_4bit between requesters; operands are compared
// one nibble per cycle, MSB first, stopping at the first unequal nibble.
module cmp_share_sequencer
    import cmp_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic                     rsp_gt,
    output logic                     rsp_eq,
    output logic                     rsp_lt
);

    localparam int unsigned NIBS = WIDTH / 4;
    localparam int unsigned ID_W = $clog2(N_REQ);
    localparam int unsigned NB_W = (NIBS > 1) ? $clog2(NIBS) : 1;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [ID_W-1:0]   id_q, id_d, last_q, last_d;
    logic [NB_W-1:0]   nib_q, nib_d;
    logic              gt_acc_q, gt_acc_d, eq_acc_q, eq_acc_d, lt_acc_q, lt_acc_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_gt_q, rsp_gt_d, rsp_eq_q, rsp_eq_d, rsp_lt_q, rsp_lt_d;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic [3:0]        nib_a, nib_b;
    logic              gt_n, eq_n, lt_n;
    logic              gt_new, eq_new, lt_new;

    cmp_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_q),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign nib_a = a_q[{nib_q, 2'b00} +: 4];
    assign nib_b = b_q[{nib_q, 2'b00} +: 4];

    // Operands are swapped at the macro so its gt/lt read as a>b / a<b here.
    cmp_4bit u_cmp (
        .a  (nib_b),
        .b  (nib_a),
        .gt (gt_n),
        .eq (eq_n),
        .lt (lt_n)
    );

    assign gt_new = gt_acc_q | (eq_acc_q & gt_n);
    assign lt_new = lt_acc_q | (eq_acc_q & lt_n);
    assign eq_new = eq_acc_q & eq_n;

    // Grant is only offered in IDLE and never while reset is held.
    assign req_ready = (state_q == IDLE && rst_n) ? grant : '0;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        last_d      = last_q;
        nib_d       = nib_q;
        gt_acc_d    = gt_acc_q;
        eq_acc_d    = eq_acc_q;
        lt_acc_d    = lt_acc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_gt_d    = rsp_gt_q;
        rsp_eq_d    = rsp_eq_q;
        rsp_lt_d    = rsp_lt_q;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (grant[i]) begin
                            a_d = req_a[i*WIDTH +: WIDTH];
                            b_d = req_b[i*WIDTH +: WIDTH];
                        end
                    end
                    id_d     = grant_idx;
                    last_d   = grant_idx;
                    nib_d    = NB_W'(NIBS - 1);
                    gt_acc_d = 1'b0;
                    eq_acc_d = 1'b1;
                    lt_acc_d = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                gt_acc_d = gt_new;
                eq_acc_d = eq_new;
                lt_acc_d = lt_new;
                if (!eq_new || nib_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_gt_d    = gt_new;
                    rsp_eq_d    = eq_new;
                    rsp_lt_d    = lt_new;
                    state_d     = RESP;
                end else begin
                    nib_d = nib_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_gt_d    = 1'b0;
                    rsp_eq_d    = 1'b0;
                    rsp_lt_d    = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, so a request in flight at reset leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            last_q      <= ID_W'(N_REQ - 1);
            nib_q       <= '0;
            gt_acc_q    <= 1'b0;
            eq_acc_q    <= 1'b0;
            lt_acc_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_gt_q    <= 1'b0;
            rsp_eq_q    <= 1'b0;
            rsp_lt_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            last_q      <= last_d;
            nib_q       <= nib_d;
            gt_acc_q    <= gt_acc_d;
            eq_acc_q    <= eq_acc_d;
            lt_acc_q    <= lt_acc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_gt_q    <= rsp_gt_d;
            rsp_eq_q    <= rsp_eq_d;
            rsp_lt_q    <= rsp_lt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_gt    = rsp_gt_q;
    assign rsp_eq    = rsp_eq_q;
    assign rsp_lt    = rsp_lt_q;

endmodule

// File: tb/tb_cmp_share_sequencer.sv
// Directed self-checking bench for cmp_share_sequencer with N_REQ=4, WIDTH=8.
module tb_cmp_share_sequencer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic        rsp_gt;
    logic        rsp_eq;
    logic        rsp_lt;

    int checks = 0;
    int errors = 0;

    cmp_share_sequencer #(.N_REQ(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_gt    (rsp_gt),
        .rsp_eq    (rsp_eq),
        .rsp_lt    (rsp_lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Returns the number of cycles spent waiting; bounded so a stuck DUT still ends.
    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < 8) begin
            tick();
            cycles++;
        end
        check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic check_rsp(input string tag, input logic [1:0] id, input logic [2:0] gel);
        check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, "_id"}, {30'd0, rsp_id}, {30'd0, id});
        check({tag, "_gel"}, {29'd0, rsp_gt, rsp_eq, rsp_lt}, {29'd0, gel});
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_drop"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_clr"}, {29'd0, rsp_gt, rsp_eq, rsp_lt}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #13;
        rst_n = 1'b1;
        #1;
    endtask

    // Per-requester operands and expected {gt,eq,lt} for the all-valid round.
    logic [7:0] rr_a   [4];
    logic [7:0] rr_b   [4];
    logic [2:0] rr_gel [4];
    logic [1:0] rr_seq [5];

    initial begin
        int cyc;
        rr_a[0] = 8'h12; rr_b[0] = 8'h34; rr_gel[0] = 3'b001;
        rr_a[1] = 8'h99; rr_b[1] = 8'h99; rr_gel[1] = 3'b010;
        rr_a[2] = 8'hF0; rr_b[2] = 8'h0F; rr_gel[2] = 3'b100;
        rr_a[3] = 8'h3C; rr_b[3] = 8'h3A; rr_gel[3] = 3'b100;
        rr_seq[0] = 2'd0; rr_seq[1] = 2'd1; rr_seq[2] = 2'd2; rr_seq[3] = 2'd3; rr_seq[4] = 2'd0;

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        do_reset();

        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_rsp", {27'd0, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_req_ready", {28'd0, req_ready}, 32'd0);
            check("idle_rsp", {27'd0, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt}, 32'd0);
        end

        // Equal operands: two RUN cycles, response three cycles after the grant.
        req_a[7:0] = 8'h5A; req_b[7:0] = 8'h5A; req_valid = 4'b0001;
        #1;
        check("eq_grant", {28'd0, req_ready}, 32'b0001);
        tick();
        req_valid = '0;
        check("eq_run1_ready", {28'd0, req_ready}, 32'd0);
        check("eq_run1", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("eq_run2", {31'd0, rsp_valid}, 32'd0);
        tick();
        check_rsp("eq", 2'd0, 3'b010);
        handshake("eq");

        // MSB nibble differs: one RUN cycle.
        req_a[23:16] = 8'h80; req_b[23:16] = 8'h7F; req_valid = 4'b0100;
        #1;
        check("gt_grant", {28'd0, req_ready}, 32'b0100);
        tick();
        req_valid = '0;
        check("gt_run1", {31'd0, rsp_valid}, 32'd0);
        tick();
        check_rsp("gt", 2'd2, 3'b100);
        handshake("gt");

        // MSB nibble equal, LSB differs: two RUN cycles.
        req_a[23:16] = 8'h37; req_b[23:16] = 8'h38; req_valid = 4'b0100;
        #1;
        check("lt_grant", {28'd0, req_ready}, 32'b0100);
        tick();
        req_valid = '0;
        check("lt_run1", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("lt_run2", {31'd0, rsp_valid}, 32'd0);
        tick();
        check_rsp("lt", 2'd2, 3'b001);
        handshake("lt");

        // Fresh pointer, all four valid: grants rotate 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = rr_a[i];
            req_b[i*8 +: 8] = rr_b[i];
        end
        req_valid = 4'b1111;
        #1;
        for (int i = 0; i < 5; i++) begin
            logic [3:0] onehot;
            onehot = 4'b0001 << rr_seq[i];
            check("rr_grant", {28'd0, req_ready}, {28'd0, onehot});
            tick();
            wait_rsp(cyc);
            check_rsp("rr", rr_seq[i], rr_gel[rr_seq[i]]);
            if (i == 0) begin
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check("stall_ready", {28'd0, req_ready}, 32'd0);
                    check_rsp("stall", rr_seq[i], rr_gel[rr_seq[i]]);
                end
            end
            handshake("rr");
            #1;
        end

        // Reset in the middle of req1's RUN phase.
        req_valid = 4'b0010;
        req_a[15:8] = 8'h11; req_b[15:8] = 8'h11;
        #1;
        check("mid_grant", {28'd0, req_ready}, 32'b0010);
        tick();
        check("mid_run1", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {28'd0, req_ready}, 32'd0);
        check("mid_rst_rsp", {27'd0, rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt}, 32'd0);
        tick();
        check("mid_hold_rsp", {31'd0, rsp_valid}, 32'd0);
        req_valid = 4'b1111;
        #3;
        rst_n = 1'b1;
        #1;
        check("post_rst_grant", {28'd0, req_ready}, 32'b0001);
        tick();
        req_valid = '0;
        wait_rsp(cyc);
        check_rsp("post_rst", 2'd0, rr_gel[0]);
        handshake("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
